// File: rtl/ifetch_unit_if.sv
// Program-memory bus between the fetch unit (master) and instruction memory (slave).
// req/addr hold until gnt; rvalid/rdata return in request order.
interface ifetch_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the PC, issues credit-limited memory requests and queues
// returned instructions with their PC+4 in an in-order prefetch FIFO feeding IF/ID.
module ifetch_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  ifetch_unit_if.master     imem,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc4
);
  localparam int unsigned       PtrW     = $clog2(DEPTH);
  localparam int unsigned       CntW     = PtrW + 1;
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] PcStep   = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   out_q, out_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] pc4_q  [DEPTH];
  logic [ADDR_W-1:0] pc4_d  [DEPTH];
  logic              granted, resp, push, pop;

  always_comb begin
    granted = req_q & imem.imem_gnt;
    // A response with nothing outstanding is a leftover from before reset.
    resp    = imem.imem_rvalid & (out_q != '0);
    push    = resp & (drop_q == '0) & ~redirect_en;
    pop     = (count_q != '0) & ~stall & ~redirect_en;

    fetch_pc_d = granted ? fetch_pc_q + PcStep : fetch_pc_q;
    resp_pc_d  = push ? resp_pc_q + PcStep : resp_pc_q;
    out_d      = out_q + CntW'(granted) - CntW'(resp);
    drop_d     = (resp && drop_q != '0) ? drop_q - CntW'(1) : drop_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    data_d     = data_q;
    pc4_d      = pc4_q;
    if (push) begin
      data_d[wr_ptr_q] = imem.imem_rdata;
      pc4_d[wr_ptr_q]  = resp_pc_q + PcStep;
    end

    // Everything still in flight after this cycle's accounting belongs to the old path.
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = out_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end

    req_d = ({1'b0, count_d} + {1'b0, out_d}) < {1'b0, DepthCnt};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      req_q      <= 1'b0;
      data_q     <= '{default: '0};
      pc4_q      <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      req_q      <= req_d;
      data_q     <= data_d;
      pc4_q      <= pc4_d;
    end
  end

  always_comb begin
    imem.imem_req  = req_q;
    imem.imem_addr = fetch_pc_q;
    inst_valid     = count_q != '0;
    inst           = data_q[rd_ptr_q];
    inst_pc4       = pc4_q[rd_ptr_q];
  end

  assert property (@(posedge clk) disable iff (!rst) (drop_q <= out_q) && (out_q <= DepthCnt));

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch front-end of the 5-stage datapath. Owns the PC and issues requests to program memory over a req/gnt/rvalid handshake. Buffers returned instructions, each paired with its PC+4, in a small in-order prefetch FIFO, and presents the FIFO head to the IF/ID pipeline register. Branch and jump redirects from the MEM-stage branch logic flush the queue and discard in-flight responses.

Parameters:
DATA_W, 32, instruction width
ADDR_W, 32, address width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
redirect_en  in  1  taken branch/jump from MEM stage
redirect_pc  in  ADDR_W  redirect target
stall  in  1  ID stage cannot accept this cycle
imem_req  out  1  program memory read request
imem_addr  out  ADDR_W  request address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid, in request order
imem_rdata  in  DATA_W  read data
inst_valid  out  1  inst/inst_pc4 valid
inst  out  DATA_W  instruction at FIFO head
inst_pc4  out  ADDR_W  PC+4 of that instruction

Behaviour:
- Reset: rst=0 at an edge sets the following, all registered:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC
  - FIFO count=0, outstanding=0, drop=0
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst=0, inst_pc4=0
- Reset mid-operation: same as above. Any rvalid arriving while outstanding=0 is ignored.
- Credit rule: imem_req=1 when (count+outstanding)<DEPTH. imem_addr=fetch_pc.
- Request hold: once imem_req is asserted, req and addr stay stable until imem_gnt. The only exception is a redirect, which may retarget the request the next cycle.
- Grant: req&gnt increments outstanding and sets fetch_pc+=4 (mod 2^ADDR_W).
- Response: rvalid with drop>0 decrements drop and outstanding and discards the data.
  - Otherwise it decrements outstanding, pushes {imem_rdata, resp_pc+4} into the FIFO and sets resp_pc+=4.
  - No bypass: a pushed entry is visible at the outputs the cycle after rvalid.
- Pop: inst_valid&!stall pops the head.
  - inst_valid = count!=0; inst/inst_pc4 come from registered FIFO storage.
  - Push and pop in the same cycle keep count unchanged. The credit rule guarantees no overflow.
- Redirect (redirect_en=1) has priority over everything, including stall, pop and push:
  - FIFO flushed, so count=0 and inst_valid=0 next cycle
  - fetch_pc=resp_pc=redirect_pc
  - drop = outstanding after this cycle's gnt/rvalid accounting: a gnt in the redirect cycle adds one to drop; an rvalid in the redirect cycle is discarded
  - the next cycle's imem_req carries redirect_pc
- Latency with a 1-cycle memory (gnt same cycle, rvalid next cycle):
  - redirect at N -> req(redirect_pc) at N+1 -> rvalid at N+2 -> inst_valid at N+3
  - reset release behaves the same way: first req one cycle after rst goes high
- Steady state with a 1-cycle memory and no stall: one instruction per cycle.
- Stall with a full queue: imem_req drops to 0 while count+outstanding=DEPTH and resumes the cycle after a pop frees a credit.
- Wrap-around: PC arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC+4=0x0000_0000.
- Invariant: drop<=outstanding<=DEPTH. Verification asserts this every cycle.

Test Plan:
- Reset/startup: rst=0 for 3 cycles, then 1, with a 1-cycle memory returning addr as data.
  - During reset: imem_req=0, inst_valid=0.
  - Then req addr=0x0, 0x4, 0x8...
  - inst_valid first high 2 cycles after the first req, with inst=0x0, inst_pc4=0x4, then one instruction per cycle.
- Backpressure: stall=1 for 10 cycles with DEPTH=4.
  - count reaches 4, imem_req falls to 0, and the head holds inst=0x0.
  - On release, outputs 0x0, 0x4, 0x8, 0xC, 0x10 with no gaps or duplicates.
- Redirect with in-flight responses: memory latency 3 cycles, 2 outstanding, redirect_pc=0x100.
  - Both stale responses are dropped and the queue empties the next cycle.
  - The first delivered inst is 0x100 with inst_pc4=0x104.
- Simultaneous events: redirect_en, gnt, rvalid and stall=1 all in one cycle.
  - The granted request is counted in drop and the arriving rvalid is discarded.
  - The next req addr is redirect_pc and no stale instruction is ever output.
- Slow grant: gnt withheld for 4 cycles.
  - imem_req and imem_addr stay stable throughout and fetch_pc advances only on gnt.
  - If a redirect arrives while waiting, the next cycle's addr equals redirect_pc.
- Wrap and reset mid-flight:
  - redirect_pc=0xFFFF_FFFC gives inst_pc4=0x0 and the next req addr=0x0.
  - Asserting rst with 2 outstanding: stale rvalids after reset are ignored and fetch restarts at RESET_PC.
